// File: rtl/rtc_timekeeper_if.sv
// rtc_timekeeper_if: control, load, alarm and time-output signals of rtc_timekeeper
interface rtc_timekeeper_if #(parameter int W = 6);
  logic run_i, fast_i, load_i, alarm_en_i, alarm_clr_i;
  logic [W-1:0] load_sec_i, load_min_i, load_hour_i;
  logic [W-1:0] alarm_sec_i, alarm_min_i, alarm_hour_i;
  logic [W-1:0] sec_o, min_o, hour_o;
  logic tick_o, day_o, alarm_o, load_err_o;
  modport master (
    output run_i, fast_i, load_i, load_sec_i, load_min_i, load_hour_i,
    output alarm_en_i, alarm_sec_i, alarm_min_i, alarm_hour_i, alarm_clr_i,
    input sec_o, min_o, hour_o, tick_o, day_o, alarm_o, load_err_o
  );
  modport slave (
    input run_i, fast_i, load_i, load_sec_i, load_min_i, load_hour_i,
    input alarm_en_i, alarm_sec_i, alarm_min_i, alarm_hour_i, alarm_clr_i,
    output sec_o, min_o, hour_o, tick_o, day_o, alarm_o, load_err_o
  );
endinterface

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: hh:mm:ss timekeeper with prescaler, range-checked load and sticky alarm
module rtc_timekeeper #(
  parameter int DIV = 10000,
  parameter int W = 6,
  parameter int SEC_MOD = 60,
  parameter int MIN_MOD = 60,
  parameter int HOUR_MOD = 24
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  rtc_timekeeper_if.slave bus
);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PC_MAX = PW'(DIV - 1);
  localparam logic [W:0] SM = (W+1)'(SEC_MOD);
  localparam logic [W:0] MM = (W+1)'(MIN_MOD);
  localparam logic [W:0] HM = (W+1)'(HOUR_MOD);
  logic [PW-1:0] pc;
  logic [W-1:0] sec_q, min_q, hour_q;
  logic tick_q, day_q, alarm_q, err_q, upd_q;
  logic tick_c, load_ok, adv, sec_w, min_w, hour_w, match;
  always_comb begin
    tick_c = bus.run_i && (bus.fast_i || pc == PC_MAX);
    load_ok = bus.load_i && {1'b0, bus.load_sec_i} < SM && {1'b0, bus.load_min_i} < MM
              && {1'b0, bus.load_hour_i} < HM;
    adv = tick_c && !load_ok;
    sec_w = {1'b0, sec_q} == SM - 1'b1;
    min_w = {1'b0, min_q} == MM - 1'b1;
    hour_w = {1'b0, hour_q} == HM - 1'b1;
    match = bus.alarm_en_i && sec_q == bus.alarm_sec_i && min_q == bus.alarm_min_i
            && hour_q == bus.alarm_hour_i;
  end
  // upd_q marks the cycle in which freshly written time is on the outputs; only then is the alarm compared
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pc <= '0;
      sec_q <= '0;
      min_q <= '0;
      hour_q <= '0;
      tick_q <= 1'b0;
      day_q <= 1'b0;
      alarm_q <= 1'b0;
      err_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      pc <= (load_ok || bus.fast_i) ? '0 : bus.run_i ? (pc == PC_MAX ? '0 : pc + 1'b1) : pc;
      if (load_ok) begin
        sec_q <= bus.load_sec_i;
        min_q <= bus.load_min_i;
        hour_q <= bus.load_hour_i;
      end else if (adv) begin
        sec_q <= sec_w ? '0 : sec_q + 1'b1;
        if (sec_w) min_q <= min_w ? '0 : min_q + 1'b1;
        if (sec_w && min_w) hour_q <= hour_w ? '0 : hour_q + 1'b1;
      end
      tick_q <= adv;
      day_q <= adv && sec_w && min_w && hour_w;
      err_q <= bus.load_i && !load_ok;
      upd_q <= adv || load_ok;
      alarm_q <= (upd_q && match) || (alarm_q && !bus.alarm_clr_i);
    end
  end
  assign bus.sec_o = sec_q;
  assign bus.min_o = min_q;
  assign bus.hour_o = hour_q;
  assign bus.tick_o = tick_q;
  assign bus.day_o = day_q;
  assign bus.alarm_o = alarm_q;
  assign bus.load_err_o = err_q;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: vector table plus hand sequences, expected outputs queued per driven cycle
module tb_rtc_timekeeper;
  typedef struct {
    string name;
    logic rst, run, fast, load, aen, clr;
    logic [5:0] ls, lm, lh, asec, amin, ahour;
    logic [5:0] es, em, eh;
    logic et, ed, ea, ee;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  logic cfg_aen = 1'b0;
  logic [5:0] cfg_as = '0, cfg_am = '0, cfg_ah = '0;
  vec_t tbl[$];
  vec_t exp_q[$];
  rtc_timekeeper_if #(.W(6)) bus ();
  rtc_timekeeper #(.DIV(4), .W(6), .SEC_MOD(60), .MIN_MOD(60), .HOUR_MOD(24)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input string n, input logic rs, run, fast, load,
                              input logic [5:0] ls, lm, lh, input logic clr,
                              input logic [5:0] es, em, eh, input logic et, ed, ea, ee);
    vec_t v;
    v.name = n; v.rst = rs; v.run = run; v.fast = fast; v.load = load;
    v.ls = ls; v.lm = lm; v.lh = lh; v.clr = clr;
    v.aen = cfg_aen; v.asec = cfg_as; v.amin = cfg_am; v.ahour = cfg_ah;
    v.es = es; v.em = em; v.eh = eh; v.et = et; v.ed = ed; v.ea = ea; v.ee = ee;
    return v;
  endfunction
  task automatic step(input vec_t v);
    vec_t e;
    logic [21:0] got, want;
    rst = v.rst;
    bus.run_i = v.run; bus.fast_i = v.fast; bus.load_i = v.load;
    bus.load_sec_i = v.ls; bus.load_min_i = v.lm; bus.load_hour_i = v.lh;
    bus.alarm_en_i = v.aen; bus.alarm_sec_i = v.asec; bus.alarm_min_i = v.amin;
    bus.alarm_hour_i = v.ahour; bus.alarm_clr_i = v.clr;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    got = {bus.hour_o, bus.min_o, bus.sec_o, bus.tick_o, bus.day_o, bus.alarm_o, bus.load_err_o};
    want = {e.eh, e.em, e.es, e.et, e.ed, e.ea, e.ee};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d:%0d:%0d tick=%b day=%b alarm=%b err=%b, want %0d:%0d:%0d tick=%b day=%b alarm=%b err=%b",
               e.name, bus.hour_o, bus.min_o, bus.sec_o, bus.tick_o, bus.day_o, bus.alarm_o,
               bus.load_err_o, e.eh, e.em, e.es, e.et, e.ed, e.ea, e.ee);
    end
  endtask
  initial begin
    for (int i = 0; i < 100; i++) tbl.push_back(mk("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 12; k++)
      tbl.push_back(mk("div_count", 0, 1, 0, 0, 0, 0, 0, 0, 6'(k / 4), 0, 0, k % 4 == 0, 0, 0, 0));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk("pre_load", 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("load_vs_tick", 0, 1, 0, 1, 30, 20, 10, 0, 30, 20, 10, 0, 0, 0, 0));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk("post_load", 0, 1, 0, 0, 0, 0, 0, 0, 30, 20, 10, 0, 0, 0, 0));
    tbl.push_back(mk("tick_after_load", 0, 1, 0, 0, 0, 0, 0, 0, 31, 20, 10, 1, 0, 0, 0));
    tbl.push_back(mk("fast_load", 0, 1, 1, 1, 58, 59, 23, 0, 58, 59, 23, 0, 0, 0, 0));
    tbl.push_back(mk("fast_59", 0, 1, 1, 0, 0, 0, 0, 0, 59, 59, 23, 1, 0, 0, 0));
    tbl.push_back(mk("day_wrap", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk("day_single", 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk("freeze", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("load_err", 0, 0, 0, 1, 60, 5, 5, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("err_single", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("load_ok", 0, 0, 0, 1, 59, 5, 5, 0, 59, 5, 5, 0, 0, 0, 0));
    tbl.push_back(mk("load_ok_quiet", 0, 0, 0, 0, 0, 0, 0, 0, 59, 5, 5, 0, 0, 0, 0));
    tbl.push_back(mk("rej_keeps_tick", 0, 1, 1, 1, 0, 0, 24, 0, 0, 6, 5, 1, 0, 0, 1));
    tbl.push_back(mk("rej_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 5, 0, 0, 0, 0));
    cfg_aen = 1; cfg_as = 3; cfg_am = 0; cfg_ah = 0;
    tbl.push_back(mk("al_load", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk("al_run", 0, 1, 1, 0, 0, 0, 0, 0, 6'(k), 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk("al_set_vs_clr", 0, 1, 1, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0, 1, 0));
    cfg_aen = 0;
    tbl.push_back(mk("al_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("al_clr", 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("al_cleared", 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("dis_load", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk("dis_run", 0, 1, 1, 0, 0, 0, 0, 0, 6'(k), 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk("dis_hold", 0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) step(tbl[i]);
    cfg_aen = 1; cfg_as = 56; cfg_am = 34; cfg_ah = 12;
    step(mk("rm_load", 0, 0, 0, 1, 56, 34, 12, 0, 56, 34, 12, 0, 0, 0, 0));
    step(mk("rm_alarm", 0, 0, 0, 0, 0, 0, 0, 0, 56, 34, 12, 0, 0, 1, 0));
    step(mk("rm_run", 0, 1, 0, 0, 0, 0, 0, 0, 56, 34, 12, 0, 0, 1, 0));
    step(mk("rm_run", 0, 1, 0, 0, 0, 0, 0, 0, 56, 34, 12, 0, 0, 1, 0));
    step(mk("rm_reset", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++)
      step(mk("rm_resume", 0, 1, 0, 0, 0, 0, 0, 0, 6'(k == 4), 0, 0, k == 4, 0, 0, 0));
    step(mk("hold_run", 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step(mk("hold_run", 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      step(mk("hold_pc", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step(mk("hold_resume", 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step(mk("hold_tick", 0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rtc_timekeeper.md
# rtc_timekeeper

Parametrised hours/minutes/seconds timekeeping core for the user project area, driven from the Wishbone clock. It supersedes the fixed digital-clock counter. It adds:
- a programmable prescaler with a fast (bypass) mode;
- per-field moduli;
- a synchronous time-load port with range checking;
- an alarm comparator with a sticky flag, plus tick and day-rollover strobes.

The three field outputs drive the mprj_io bit-fields directly; control inputs come from logic analyzer or GPIO.

## Interface
Parameters:
- DIV, 10000, prescaler period in clock cycles per second tick; legal range ≥ 2
- W, 6, width of each time field
- SEC_MOD, 60, seconds modulus; must satisfy 2 ≤ SEC_MOD ≤ 2^W
- MIN_MOD, 60, minutes modulus; same constraint
- HOUR_MOD, 24, hours modulus; same constraint

Ports:
- wb_clk_i  in  1  single clock; all logic on its rising edge
- wb_rst_i  in  1  synchronous reset, active-high
- run_i  in  1  count enable; 0 freezes the prescaler and the time
- fast_i  in  1  prescaler bypass; with run_i=1, one tick every cycle
- load_i  in  1  one-cycle strobe; loads load_sec_i, load_min_i and load_hour_i
- load_sec_i, load_min_i, load_hour_i  in  W each  time values to load
- alarm_en_i  in  1  enables alarm matching
- alarm_sec_i, alarm_min_i, alarm_hour_i  in  W each  alarm time, sampled live
- alarm_clr_i  in  1  clears alarm_o
- sec_o, min_o, hour_o  out  W each  current time, registered
- tick_o  out  1  one-cycle pulse when the time advanced by one second
- day_o  out  1  one-cycle pulse on rollover to 00:00:00
- alarm_o  out  1  sticky alarm flag
- load_err_o  out  1  one-cycle pulse when a load is rejected

## Operation
- The prescaler counter pc counts 0..DIV-1 while run_i=1 and fast_i=0.
  - At pc=DIV-1 a tick is generated and pc wraps to 0.
  - run_i=0 holds pc; it is not cleared.
- fast_i=1 holds pc at 0, and every cycle with run_i=1 is a tick.
- On a tick, seconds increment.
  - At SEC_MOD-1, seconds wrap to 0 and minutes increment.
  - Minutes wrap at MIN_MOD-1 and carry into hours.
  - Hours wrap at HOUR_MOD-1 to 0.
  - A full wrap of all three fields asserts day_o.
- Arithmetic: each field is unsigned W-bit and never holds a value ≥ its modulus.
- Load:
  - Accepted only if load_sec_i<SEC_MOD, load_min_i<MIN_MOD and load_hour_i<HOUR_MOD.
  - An accepted load writes all three fields and clears pc to 0.
  - Any out-of-range field rejects the whole load: time and pc are unchanged and load_err_o pulses.
- Load and tick in the same cycle: the load has priority and the tick is discarded (no tick_o, no day_o). A rejected load does not suppress the tick.
- Alarm:
  - Evaluated only in the cycle after the time registers change (tick or accepted load).
  - If alarm_en_i=1 and all three fields equal the alarm inputs, alarm_o is set.
  - alarm_clr_i clears alarm_o. A set and a clear in the same cycle resolve to set.
  - alarm_en_i=0 blocks setting but does not clear alarm_o.
- Reset: pc, all fields, tick_o, day_o, alarm_o and load_err_o go to 0. Reset overrides every other input in that cycle.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Tick condition in cycle N (pc=DIV-1 or fast): the new time and tick_o appear in cycle N+1. day_o is coincident with the 00:00:00 value.
- With fast_i=0, after run_i rises with pc=0, the first tick_o occurs DIV cycles later. Subsequent ticks are spaced exactly DIV cycles.
- load_i in cycle N: the loaded time, or load_err_o, is visible in N+1.
- Alarm latency: alarm_o rises one cycle after the matching time appears on the outputs.
- Reset asserted mid-count: the outputs read 0 in the cycle after reset is sampled. Counting resumes from pc=0 once wb_rst_i=0.

## Test plan
- Reset with run_i=0 for 100 cycles -> all outputs 0 throughout; run_i=1, fast_i=0, DIV=4 -> sec_o = 1, 2, 3… spaced 4 cycles apart, with tick_o coincident each time.
- fast_i=1, load 23:59:58 -> 23:59:58 next cycle, then 23:59:59, then 00:00:00 with day_o=1 for that single cycle only.
- load_sec_i=60 (min 5, hour 5) -> load_err_o pulses one cycle and time is unchanged; then load 05:05:59 -> accepted and load_err_o stays 0.
- fast_i=1 from 00:00:00, alarm 00:00:03 with alarm_en_i=1 -> alarm_o rises the cycle after sec_o=3 and remains set; alarm_clr_i -> alarm_o=0 next cycle. alarm_en_i=0 over the same sequence -> alarm_o stays 0.
- load_i asserted in the same cycle as a tick (DIV=4, pc=3), loading 10:20:30 -> the output is 10:20:30 (not :31), no tick_o, and the next tick follows 4 cycles later.
- wb_rst_i asserted mid-count at 12:34:56 -> all outputs 0 the next cycle, including a pending alarm_o.
